instr_reorder_buffer: RTL and testbench
=======================================

// Module: instr_reorder_buffer
// PURPOSE
//  Parametrised successor of the single-port instruction buffer. Sequentially captures an instruction stream, then emits entries in
//  mapping-table index order, refilling each emptied slot with the next incoming word (swap). Explicit in_last end-of-stream marker;
//  start is valid for streams both shorter and longer than DEPTH. Sits between fetch and the mapping-table-driven issue stage.
// PARAMETERS
//  IW     32  instruction word width (bits)
//  DEPTH  16  buffer entries; power of 2, >=2
//  AW     $clog2(DEPTH)  index width (derived, localparam)
// PORTS
//  clk        in   1     sole clock, rising edge
//  rst_n      in   1     reset: asynchronous, active-low
//  flush      in   1     sync clear: all entries invalid, FSM->IDLE, err cleared
//  in_valid   in   1     incoming instruction valid
//  in_ready   out  1     buffer accepts in_data this cycle
//  in_data    in   IW    instruction word
//  in_last    in   1     in_data is final word of stream
//  idx_valid  in   1     mapping-table index valid
//  idx_ready  out  1     index consumed this cycle
//  idx        in   AW    slot to emit
//  out_valid  out  1     out_data valid (1-deep output register)
//  out_ready  in   1     downstream accepts out_data
//  out_data   out  IW    emitted instruction
//  start      out  1     indexed reads allowed (state RUN or DRAIN)
//  count      out  AW+1  number of valid entries
//  err        out  1     sticky: index addressed an invalid slot
// BEHAVIOUR
//  Reset (rst_n=0, async): state IDLE, all valid bits 0, wr_ptr 0, out_valid 0, out_data 0, count 0, err 0; start/in_ready/idx_ready 0.
//  slot_free = !out_valid | out_ready. Handshake fires on valid&ready; valid signals must not depend on ready.
//  States:
//   IDLE : in_ready=1, idx_ready=0. Accepted word -> slot 0, wr_ptr=1, ->FILL (in_last -> DRAIN).
//   FILL : in_ready=1, idx_ready=0. Word -> slot wr_ptr, valid set, wr_ptr++. in_last accepted -> DRAIN;
//          else word into slot DEPTH-1 -> RUN. wr_ptr never wraps.
//   RUN  : buffer full. Fire = idx_valid & in_valid & slot_free; in_ready = idx_valid & slot_free;
//          idx_ready = in_valid & slot_free. On fire: out_data<=buf[idx], out_valid<=1, buf[idx]<=in_data (valid stays 1).
//          in_last on fire -> DRAIN.
//   DRAIN: in_ready=0; idx_ready=slot_free. On fire with valid[idx]: emit, clear valid[idx], count--. Invalid idx: consumed,
//          no emit, err<=1. count==0 (incl. after final decrement) -> IDLE next cycle.
//  Latency: out_data/out_valid registered, 1 cycle after fire. Read-before-write on same slot: old word emitted, new stored.
//  out_valid clears on out_ready when no new fire; held stable while out_ready=0.
//  count: +1 per FILL/IDLE write, -1 per DRAIN emit, unchanged on RUN swap; never exceeds DEPTH.
//  flush: priority over every event same cycle; out_valid<=0. Reset mid-stream: everything discarded, state IDLE.
//  start=1 iff state in {RUN,DRAIN}; goes 1 the cycle after last FILL write / in_last.
// STRUCTURE
//  Package instr_buf_pkg: state_t enum {IDLE,FILL,RUN,DRAIN}; IDX_W(depth) width function.
//  Sub-module instr_buf_mem: DEPTH x IW register array + valid vector, 1 sync write, 1 async read, valid set/clear, async
//  active-low reset of valid bits only. FSM, counters and output register live in the top.
// TESTING
//  1. DEPTH=16, 16 words 1..16 then indices 15..0 each with new word 101..116 -> out 16..1, count stays 16, no err.
//  2. 5 words 0xA..0xE, in_last on 0xE -> start after 5th, DRAIN; idx 4,0,2,1,3 -> E,A,C,B,D; count 5..0; IDLE.
//  3. DRAIN with idx=7 on 3-entry stream -> no out_valid, err=1 sticky until flush.
//  4. out_ready=0 for 4 cycles in RUN -> out_data held, idx_ready=0, in_ready=0, no slot written.
//  5. in_last on first word -> DRAIN, count=1, idx 0 -> word out, IDLE.
//  6. rst_n low mid-RUN / flush with fire -> flush wins, count 0, out_valid 0, start 0, next word lands slot 0.

Source files
------------

// File: rtl/instr_buf_pkg.sv
// Shared types and helpers for the instruction reorder buffer.
// Holds the FSM state encoding and the index-width helper.
package instr_buf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        DRAIN
    } state_t;

    function automatic int IDX_W(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/instr_buf_mem.sv
// Storage for the reorder buffer: DEPTH x IW word array plus per-slot valid bits.
// One synchronous write port, one asynchronous read port. Only the valid bits are reset.
module instr_buf_mem
    import instr_buf_pkg::*;
#(
    parameter  int IW    = 32,
    parameter  int DEPTH = 16,
    localparam int AW    = IDX_W(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_all,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [IW-1:0]    wdata,
    input  logic             vld_clr,
    input  logic [AW-1:0]    clr_addr,
    input  logic [AW-1:0]    raddr,
    output logic [IW-1:0]    rdata,
    output logic [DEPTH-1:0] valid
);

    logic [IW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read is combinational so a same-cycle swap returns the old word.
    assign rdata = mem[raddr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (clr_all) begin
            valid <= '0;
        end else begin
            if (we) begin
                valid[waddr] <= 1'b1;
            end
            if (vld_clr) begin
                valid[clr_addr] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/instr_reorder_buffer.sv
// Instruction reorder buffer: captures a stream sequentially, then emits entries in
// mapping-table index order, refilling each emptied slot with the next incoming word.
module instr_reorder_buffer
    import instr_buf_pkg::*;
#(
    parameter  int IW    = 32,
    parameter  int DEPTH = 16,
    localparam int AW    = IDX_W(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_data,
    input  logic          in_last,
    input  logic          idx_valid,
    output logic          idx_ready,
    input  logic [AW-1:0] idx,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_data,
    output logic          start,
    output logic [AW:0]   count,
    output logic          err
);

    state_t           state;
    state_t           state_nxt;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    wr_ptr_nxt;
    logic [AW:0]      count_nxt;
    logic             slot_free;
    logic             in_rdy_c;
    logic             idx_rdy_c;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic             mem_clr;
    logic             emit;
    logic             err_set;
    logic [IW-1:0]    rd_data;
    logic [DEPTH-1:0] valid;

    instr_buf_mem #(
        .IW    (IW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_all  (flush),
        .we       (mem_we && !flush),
        .waddr    (mem_waddr),
        .wdata    (in_data),
        .vld_clr  (mem_clr && !flush),
        .clr_addr (idx),
        .raddr    (idx),
        .rdata    (rd_data),
        .valid    (valid)
    );

    assign slot_free = !out_valid || out_ready;

    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        count_nxt  = count;
        in_rdy_c   = 1'b0;
        idx_rdy_c  = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = wr_ptr;
        mem_clr    = 1'b0;
        emit       = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                in_rdy_c = 1'b1;
                if (in_valid) begin
                    mem_we     = 1'b1;
                    mem_waddr  = '0;
                    wr_ptr_nxt = AW'(1);
                    count_nxt  = count + (AW+1)'(1);
                    state_nxt  = in_last ? DRAIN : FILL;
                end
            end
            FILL: begin
                in_rdy_c = 1'b1;
                if (in_valid) begin
                    mem_we    = 1'b1;
                    count_nxt = count + (AW+1)'(1);
                    if (in_last) begin
                        state_nxt = DRAIN;
                    end else if (wr_ptr == AW'(DEPTH-1)) begin
                        state_nxt = RUN;
                    end else begin
                        wr_ptr_nxt = wr_ptr + AW'(1);
                    end
                end
            end
            RUN: begin
                // A swap needs both an index and a replacement word.
                in_rdy_c  = idx_valid && slot_free;
                idx_rdy_c = in_valid && slot_free;
                if (in_valid && idx_valid && slot_free) begin
                    mem_we    = 1'b1;
                    mem_waddr = idx;
                    emit      = 1'b1;
                    if (in_last) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                idx_rdy_c = slot_free;
                if (idx_valid && slot_free) begin
                    if (valid[idx]) begin
                        emit      = 1'b1;
                        mem_clr   = 1'b1;
                        count_nxt = count - (AW+1)'(1);
                    end else begin
                        err_set = 1'b1;
                    end
                end
                if (count_nxt == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshakes are held off while reset is asserted.
    assign in_ready  = in_rdy_c && rst_n;
    assign idx_ready = idx_rdy_c && rst_n;
    assign start     = (state == RUN) || (state == DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_ptr_nxt;
            count  <= count_nxt;
            if (emit) begin
                out_valid <= 1'b1;
                out_data  <= rd_data;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_reorder_buffer.sv
// Bench for instr_reorder_buffer: directed and randomized steps checked against
// a slot-array reference model of the buffer's capture / swap / drain behaviour.
module tb_instr_reorder_buffer;

    localparam int IW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    localparam int P_IDLE  = 0;
    localparam int P_FILL  = 1;
    localparam int P_RUN   = 2;
    localparam int P_DRAIN = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          idx_valid = 1'b0;
    logic          idx_ready;
    logic [AW-1:0] idx = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] out_data;
    logic          start;
    logic [AW:0]   count;
    logic          err;

    always #5 clk = ~clk;

    instr_reorder_buffer #(
        .IW    (IW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .idx       (idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .start     (start),
        .count     (count),
        .err       (err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the buffer as an array of slots with occupancy flags.
    int            m_phase;
    logic [IW-1:0] m_buf [DEPTH];
    bit            m_vld [DEPTH];
    bit            m_ov;
    logic [IW-1:0] m_od;
    bit            m_err;

    logic [IW-1:0] t2_exp [5];
    logic [IW-1:0] held;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += m_vld[i] ? 1 : 0;
        return n;
    endfunction

    task automatic m_reset();
        m_phase = P_IDLE;
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
        m_ov  = 1'b0;
        m_od  = '0;
        m_err = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, out_valid, m_ov);
        if (m_ov) chk({tag, ".out_data"}, out_data, m_od);
        chk({tag, ".count"}, count, m_count());
        chk({tag, ".start"}, start, (m_phase == P_RUN) || (m_phase == P_DRAIN));
        chk({tag, ".err"}, err, m_err);
    endtask

    // One clock: apply inputs, check ready signals, advance model, check registered outputs.
    task automatic cyc(input bit iv, input logic [IW-1:0] d, input bit last, input bit xv,
                       input logic [AW-1:0] ix, input bit ordy, input bit fl);
        bit sf;
        bit e_ir;
        bit e_xr;
        int slot;
        in_valid  = iv;
        in_data   = d;
        in_last   = last;
        idx_valid = xv;
        idx       = ix;
        out_ready = ordy;
        flush     = fl;
        #1;
        sf = !m_ov || ordy;
        case (m_phase)
            P_IDLE, P_FILL: begin e_ir = 1'b1;    e_xr = 1'b0; end
            P_RUN:          begin e_ir = xv && sf; e_xr = iv && sf; end
            default:        begin e_ir = 1'b0;    e_xr = sf; end
        endcase
        chk("in_ready", in_ready, e_ir);
        chk("idx_ready", idx_ready, e_xr);
        @(posedge clk);
        if (fl) begin
            m_phase = P_IDLE;
            for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
            m_ov  = 1'b0;
            m_err = 1'b0;
        end else begin
            if (ordy) m_ov = 1'b0;
            case (m_phase)
                P_IDLE, P_FILL: if (iv) begin
                    slot = m_count();
                    m_buf[slot] = d;
                    m_vld[slot] = 1'b1;
                    if (last) m_phase = P_DRAIN;
                    else if (slot == DEPTH-1) m_phase = P_RUN;
                    else m_phase = P_FILL;
                end
                P_RUN: if (iv && xv && sf) begin
                    m_od = m_buf[ix];
                    m_ov = 1'b1;
                    m_buf[ix] = d;
                    if (last) m_phase = P_DRAIN;
                end
                default: begin
                    if (xv && sf) begin
                        if (m_vld[ix]) begin
                            m_od = m_buf[ix];
                            m_ov = 1'b1;
                            m_vld[ix] = 1'b0;
                        end else begin
                            m_err = 1'b1;
                        end
                    end
                    if (m_count() == 0) m_phase = P_IDLE;
                end
            endcase
        end
        @(negedge clk);
        check_outputs("cyc");
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, $urandom, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    function automatic logic [AW-1:0] pick_idx();
        int base = $urandom_range(DEPTH-1);
        if ($urandom_range(3) != 0) begin
            for (int k = 0; k < DEPTH; k++)
                if (m_vld[(base + k) % DEPTH]) return AW'((base + k) % DEPTH);
        end
        return AW'(base);
    endfunction

    task automatic drain_all(input string tag, input int bound);
        for (int n = 0; n < bound && m_phase == P_DRAIN; n++)
            cyc(1'b0, $urandom, 1'b0, $urandom_range(3) != 0, pick_idx(), $urandom_range(2) != 0, 1'b0);
        chk({tag, ".drained"}, start, 1'b0);
    endtask

    initial begin
        t2_exp[0] = 32'hE; t2_exp[1] = 32'hA; t2_exp[2] = 32'hC;
        t2_exp[3] = 32'hB; t2_exp[4] = 32'hD;
        m_reset();

        #2;
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.out_data", out_data, '0);
        chk("rst.count", count, '0);
        chk("rst.start", start, 1'b0);
        chk("rst.err", err, 1'b0);
        chk("rst.in_ready", in_ready, 1'b0);
        chk("rst.idx_ready", idx_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full buffer, reverse-order swaps.
        for (int i = 1; i <= DEPTH; i++) cyc(1'b1, IW'(i), 1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("t1.start", start, 1'b1);
        for (int k = 0; k < DEPTH; k++) begin
            cyc(1'b1, IW'(101 + k), 1'b0, 1'b1, AW'(15 - k), 1'b1, 1'b0);
            chk("t1.out", out_data, IW'(16 - k));
            chk("t1.count", count, DEPTH);
        end
        for (int n = 0; n < 80; n++)
            cyc($urandom_range(3) != 0, $urandom, 1'b0, $urandom_range(3) != 0,
                AW'($urandom_range(DEPTH-1)), $urandom_range(2) != 0, 1'b0);
        for (int n = 0; n < 8 && m_phase == P_RUN; n++)
            cyc(1'b1, $urandom, 1'b1, 1'b1, AW'($urandom_range(DEPTH-1)), 1'b1, 1'b0);
        drain_all("t1", 400);
        cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Short stream, explicit drain order.
        for (int i = 0; i < 5; i++) cyc(1'b1, IW'(32'hA + i), i == 4, 1'b0, '0, 1'b1, 1'b0);
        chk("t2.start", start, 1'b1);
        chk("t2.count", count, 5);
        for (int k = 0; k < 5; k++) begin
            idx = '0;
            case (k)
                0: cyc(1'b0, '0, 1'b0, 1'b1, AW'(4), 1'b1, 1'b0);
                1: cyc(1'b0, '0, 1'b0, 1'b1, AW'(0), 1'b1, 1'b0);
                2: cyc(1'b0, '0, 1'b0, 1'b1, AW'(2), 1'b1, 1'b0);
                3: cyc(1'b0, '0, 1'b0, 1'b1, AW'(1), 1'b1, 1'b0);
                default: cyc(1'b0, '0, 1'b0, 1'b1, AW'(3), 1'b1, 1'b0);
            endcase
            chk("t2.out", out_data, t2_exp[k]);
            chk("t2.count", count, 4 - k);
        end
        chk("t2.idle", start, 1'b0);

        // Invalid index during drain sets sticky err.
        for (int i = 0; i < 3; i++) cyc(1'b1, $urandom, i == 2, 1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, AW'(7), 1'b1, 1'b0);
        chk("t3.err", err, 1'b1);
        chk("t3.no_out", out_valid, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b0, '0, 1'b0, 1'b1, AW'(k), 1'b1, 1'b0);
        chk("t3.err_sticky", err, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        chk("t3.err_flush", err, 1'b0);

        // Downstream stall in RUN.
        fill_random(DEPTH);
        cyc(1'b1, $urandom, 1'b0, 1'b1, AW'($urandom_range(DEPTH-1)), 1'b0, 1'b0);
        held = out_data;
        for (int n = 0; n < 4; n++) begin
            cyc(1'b1, $urandom, 1'b0, 1'b1, AW'($urandom_range(DEPTH-1)), 1'b0, 1'b0);
            chk("t4.hold", out_data, held);
        end
        for (int k = 0; k < DEPTH; k++) cyc(1'b1, $urandom, 1'b0, 1'b1, AW'(k), 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Single-word stream.
        cyc(1'b1, 32'h5A5A_0001, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        chk("t5.start", start, 1'b1);
        chk("t5.count", count, 1);
        cyc(1'b0, '0, 1'b0, 1'b1, '0, 1'b1, 1'b0);
        chk("t5.out", out_data, 32'h5A5A_0001);
        chk("t5.idle", start, 1'b0);

        // Flush concurrent with a RUN swap.
        fill_random(DEPTH);
        for (int n = 0; n < 3; n++) cyc(1'b1, $urandom, 1'b0, 1'b1, AW'($urandom_range(DEPTH-1)), 1'b1, 1'b0);
        cyc(1'b1, $urandom, 1'b0, 1'b1, AW'(3), 1'b1, 1'b1);
        chk("t6.flush_count", count, 0);
        chk("t6.flush_ov", out_valid, 1'b0);
        chk("t6.flush_start", start, 1'b0);
        cyc(1'b1, 32'hC0DE_0006, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, '0, 1'b1, 1'b0);
        chk("t6.slot0", out_data, 32'hC0DE_0006);

        // Asynchronous reset in the middle of RUN.
        fill_random(DEPTH);
        cyc(1'b1, $urandom, 1'b0, 1'b1, AW'(5), 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.areset_count", count, 0);
        chk("t6.areset_ov", out_valid, 1'b0);
        chk("t6.areset_start", start, 1'b0);
        chk("t6.areset_in_ready", in_ready, 1'b0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 32'hBEEF_0007, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, '0, 1'b1, 1'b0);
        chk("t6.after_reset", out_data, 32'hBEEF_0007);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
